// File: rtl/tcm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_ctrl
//  Purpose  : Tightly-coupled-memory controller. Arbitrates an IFU port and
//             an LSU port onto one single-port synchronous SRAM (1-cycle read
//             latency). Each port gets its responses back in command order
//             through a small per-port response FIFO with valid/ready flow
//             control.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             ifu_cmd_* / lsu_cmd_* - command channels (valid/ready, read,
//                                     addr, wmask, wdata)
//             ifu_rsp_* / lsu_rsp_* - response channels (valid/ready, rdata)
//             ram_*                 - SRAM macro interface
//  Revision : 1.0  initial release
// ============================================================================
module tcm_ctrl #(
    parameter int AW        = 14,
    parameter int DW        = 32,
    parameter int MW        = DW / 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_cmd_valid,
    output logic          ifu_cmd_ready,
    input  logic          ifu_cmd_read,
    input  logic [AW-1:0] ifu_cmd_addr,
    input  logic [MW-1:0] ifu_cmd_wmask,
    input  logic [DW-1:0] ifu_cmd_wdata,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_rdata,
    input  logic          lsu_cmd_valid,
    output logic          lsu_cmd_ready,
    input  logic          lsu_cmd_read,
    input  logic [AW-1:0] lsu_cmd_addr,
    input  logic [MW-1:0] lsu_cmd_wmask,
    input  logic [DW-1:0] lsu_cmd_wdata,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int CW = $clog2(RSP_DEPTH + 1);  // FIFO occupancy width
    localparam int PW = $clog2(RSP_DEPTH);      // FIFO pointer width

    // Port index 0 = IFU, 1 = LSU throughout.
    logic [1:0]         cmd_valid;
    logic [1:0]         rsp_ready;
    logic [1:0]         rsp_valid;
    logic [1:0][DW-1:0] rsp_rdata;
    logic [1:0]         elig;
    logic [1:0]         req;
    logic [1:0]         grant;
    logic               sel_lsu;
    logic               sel_read;

    logic               last_grant;   // 1 = LSU was granted last
    logic               s1_valid;
    logic               s1_port;
    logic               s1_read;
    logic [DW-1:0]      s1_data;

    assign cmd_valid = {lsu_cmd_valid, ifu_cmd_valid};
    assign rsp_ready = {lsu_rsp_ready, ifu_rsp_ready};

    // ------------------------------------------------------------------
    // Arbitration. grant already includes eligibility, so it doubles as
    // cmd_ready. Round-robin only matters when both ports compete.
    // ------------------------------------------------------------------
    assign req = cmd_valid & elig;

    always_comb begin
        grant = 2'b00;
        if (rst) begin
            grant = 2'b00;
        end else if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    assign ifu_cmd_ready = grant[0];
    assign lsu_cmd_ready = grant[1];

    // SRAM drive: idle cycles leave address/data following the IFU port.
    assign sel_lsu  = grant[1];
    assign sel_read = sel_lsu ? lsu_cmd_read : ifu_cmd_read;
    assign ram_cs   = |grant;
    assign ram_we   = (|grant) & ~sel_read;
    assign ram_addr = sel_lsu ? lsu_cmd_addr  : ifu_cmd_addr;
    assign ram_wem  = sel_lsu ? lsu_cmd_wmask : ifu_cmd_wmask;
    assign ram_din  = sel_lsu ? lsu_cmd_wdata : ifu_cmd_wdata;

    // ------------------------------------------------------------------
    // Stage 1: the access issued last cycle; ram_dout is valid now.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            s1_valid   <= 1'b0;
            s1_port    <= 1'b0;
            s1_read    <= 1'b0;
        end else begin
            s1_valid <= |grant;
            s1_port  <= sel_lsu;
            s1_read  <= sel_read;
            if (|grant) begin
                last_grant <= sel_lsu;
            end
        end
    end

    assign s1_data = s1_read ? ram_dout : '0;

    // ------------------------------------------------------------------
    // Per-port response FIFO plus eligibility.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam logic PID = 1'(p);

        logic [CW-1:0] count;
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [DW-1:0] mem [RSP_DEPTH];
        logic          push;
        logic          pop;
        logic [CW:0]   outstanding;

        assign push = s1_valid && (s1_port == PID);
        assign pop  = (count != '0) && rsp_ready[p];

        // The stage-1 entry for this port is exactly the pending push.
        // A same-cycle pop frees a slot, hence the rsp_ready -> cmd_ready
        // path. pop implies count > 0, so the subtraction cannot wrap.
        assign outstanding = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
        assign elig[p]     = outstanding < (CW+1)'(RSP_DEPTH);

        assign rsp_valid[p] = (count != '0);
        assign rsp_rdata[p] = mem[rd_ptr];

        // RSP_DEPTH is a power of two, so pointers wrap naturally.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= s1_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign ifu_rsp_valid = rsp_valid[0];
    assign ifu_rsp_rdata = rsp_rdata[0];
    assign lsu_rsp_valid = rsp_valid[1];
    assign lsu_rsp_rdata = rsp_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_tcm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcm_ctrl
//  Purpose  : Self-checking bench for tcm_ctrl. Expected responses are queued
//             per port as commands are issued; a monitor pops and compares
//             whenever a response is transferred. Includes a behavioural
//             SRAM with one-cycle read latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tcm_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_cmd_valid = 1'b0, ifu_cmd_ready, ifu_cmd_read = 1'b0;
    logic [AW-1:0] ifu_cmd_addr = '0;
    logic [MW-1:0] ifu_cmd_wmask = '0;
    logic [DW-1:0] ifu_cmd_wdata = '0;
    logic          ifu_rsp_valid, ifu_rsp_ready = 1'b1;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_cmd_valid = 1'b0, lsu_cmd_ready, lsu_cmd_read = 1'b0;
    logic [AW-1:0] lsu_cmd_addr = '0;
    logic [MW-1:0] lsu_cmd_wmask = '0;
    logic [DW-1:0] lsu_cmd_wdata = '0;
    logic          lsu_rsp_valid, lsu_rsp_ready = 1'b1;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    tcm_ctrl #(.AW(AW), .DW(DW), .MW(MW), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready),
        .ifu_cmd_read(ifu_cmd_read), .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_cmd_wmask(ifu_cmd_wmask), .ifu_cmd_wdata(ifu_cmd_wdata),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready),
        .lsu_cmd_read(lsu_cmd_read), .lsu_cmd_addr(lsu_cmd_addr),
        .lsu_cmd_wmask(lsu_cmd_wmask), .lsu_cmd_wdata(lsu_cmd_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Untouched SRAM words hold a known pattern; two words are hand-set.
    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        if (a == 14'h10) return 32'hDEADBEEF;
        if (a == 14'h20) return 32'hAABBCCDD;
        return 32'hA5A50000 | {18'd0, a};
    endfunction

    // Behavioural SRAM: byte-masked write, registered read.
    logic [31:0] sram [logic [AW-1:0]];
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_cs) begin
            w = sram.exists(ram_addr) ? sram[ram_addr] : init_word(ram_addr);
            if (ram_we) begin
                for (int b = 0; b < MW; b++)
                    if (ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
                sram[ram_addr] = w;
            end else begin
                ram_dout <= w;
            end
        end
    end

    // Scoreboard queues and activity logs.
    logic [31:0] exp_q [2][$];
    bit          log_en = 1'b0;
    bit          gord [$];      // grant order: 0 = IFU, 1 = LSU
    int          ifu_acc [$];   // IFU accept cycles
    int          ifu_rsp [$];   // IFU response transfer cycles
    int          outst [2];

    // Monitor: compare every transferred response against the queue head.
    always @(negedge clk) begin
        logic [1:0]       fire;
        logic [1:0]       acc;
        logic [1:0][31:0] data;
        logic [31:0]      e;
        fire = {lsu_rsp_valid & lsu_rsp_ready, ifu_rsp_valid & ifu_rsp_ready};
        acc  = {lsu_cmd_valid & lsu_cmd_ready, ifu_cmd_valid & ifu_cmd_ready};
        data = {lsu_rsp_rdata, ifu_rsp_rdata};
        if (rst) begin
            outst[0] = 0;
            outst[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (fire[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected port%0d: got %h, required no response", p, data[p]);
                    end else begin
                        e = exp_q[p].pop_front();
                        chk(p ? "lsu_rsp_rdata" : "ifu_rsp_rdata", data[p], e);
                    end
                    outst[p]--;
                end
                if (acc[p]) begin
                    outst[p]++;
                    chk(p ? "lsu_no_overflow" : "ifu_no_overflow", 32'(outst[p] <= 2), 32'd1);
                end
            end
            if (log_en) begin
                if (acc[0]) begin gord.push_back(1'b0); ifu_acc.push_back(cyc); end
                if (acc[1]) gord.push_back(1'b1);
                if (fire[0]) ifu_rsp.push_back(cyc);
            end
        end
    end

    // Issue one command on port p and hold it until accepted.
    task automatic send(input bit p, input bit rd, input logic [AW-1:0] a,
                        input logic [MW-1:0] m, input logic [31:0] d, input logic [31:0] exp);
        exp_q[p].push_back(exp);
        if (p) begin
            lsu_cmd_valid = 1'b1; lsu_cmd_read = rd; lsu_cmd_addr = a;
            lsu_cmd_wmask = m; lsu_cmd_wdata = d;
        end else begin
            ifu_cmd_valid = 1'b1; ifu_cmd_read = rd; ifu_cmd_addr = a;
            ifu_cmd_wmask = m; ifu_cmd_wdata = d;
        end
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (p ? lsu_cmd_ready : ifu_cmd_ready) break;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cmd_timeout port%0d: got ready=0 for 200 cycles, required accept", p);
                break;
            end
        end
        @(posedge clk); #1;
        if (p) lsu_cmd_valid = 1'b0; else ifu_cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        ifu_cmd_valid = 1'b1;
        lsu_cmd_valid = 1'b1;
        #12;
        chk("rst_ifu_cmd_ready", ifu_cmd_ready, 0);
        chk("rst_lsu_cmd_ready", lsu_cmd_ready, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_ifu_rsp_rdata", ifu_rsp_rdata, 0);
        chk("rst_lsu_rsp_rdata", lsu_rsp_rdata, 0);
        ifu_cmd_valid = 1'b0;
        lsu_cmd_valid = 1'b0;
        #4 rst = 1'b0;
        idle(2);

        // ---------------- single IFU read, latency ----------------
        exp_q[0].push_back(32'hDEADBEEF);
        ifu_cmd_valid = 1'b1; ifu_cmd_read = 1'b1; ifu_cmd_addr = 14'h10;
        @(negedge clk);
        chk("t1_cmd_ready", ifu_cmd_ready, 1);
        chk("t1_ram_cs", ram_cs, 1);
        chk("t1_ram_we", ram_we, 0);
        chk("t1_ram_addr", 32'(ram_addr), 32'h10);
        @(posedge clk); #1;
        ifu_cmd_valid = 1'b0;
        @(negedge clk); chk("t1_rsp_valid_T1", ifu_rsp_valid, 0);
        @(negedge clk); chk("t1_rsp_valid_T2", ifu_rsp_valid, 1);
        @(negedge clk); chk("t1_rsp_valid_T3", ifu_rsp_valid, 0);
        idle(2);

        // ---------------- LSU masked write, zero-mask write, readback ----------------
        send(1'b1, 1'b0, 14'h20, 4'b0101, 32'h11223344, 32'h0);
        send(1'b1, 1'b1, 14'h20, 4'b0000, 32'h0,        32'hAA22CC44);
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 14'h20;
        lsu_cmd_wmask = 4'b0000; lsu_cmd_wdata = 32'hFFFFFFFF;
        exp_q[1].push_back(32'h0);
        @(negedge clk);
        chk("wm0_ram_cs", ram_cs, 1);
        chk("wm0_ram_we", ram_we, 1);
        chk("wm0_ram_wem", 32'(ram_wem), 0);
        @(posedge clk); #1;
        lsu_cmd_valid = 1'b0;
        send(1'b1, 1'b1, 14'h20, 4'b0000, 32'h0, 32'hAA22CC44);
        idle(4);

        // ---------------- both ports competing: alternation ----------------
        gord.delete();
        log_en = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 14'(14'h40 + i), 4'h0, 32'h0, init_word(14'(14'h40 + i)));
            for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 14'(14'h50 + i), 4'h0, 32'h0, init_word(14'(14'h50 + i)));
        join
        log_en = 1'b0;
        chk("rr_grant_count", gord.size(), 8);
        for (int i = 0; i < gord.size(); i++) chk("rr_grant_order", 32'(gord[i]), 32'(i % 2));
        idle(4);

        // ---------------- IFU backpressure, LSU continues ----------------
        ifu_rsp_ready = 1'b0;
        gord.delete();
        log_en = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 14'(14'h60 + i), 4'h0, 32'h0, init_word(14'(14'h60 + i)));
            for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 14'(14'h70 + i), 4'h0, 32'h0, init_word(14'(14'h70 + i)));
            begin
                int ni, nl;
                repeat (10) @(negedge clk);
                ni = 0; nl = 0;
                foreach (gord[i]) if (gord[i]) nl++; else ni++;
                chk("bp_ifu_accepted", ni, 2);
                chk("bp_lsu_accepted", nl, 3);
                chk("bp_ifu_cmd_ready", ifu_cmd_ready, 0);
                chk("bp_ifu_rsp_valid", ifu_rsp_valid, 1);
                @(posedge clk); #1;
                ifu_rsp_ready = 1'b1;
            end
        join
        log_en = 1'b0;
        idle(6);

        // ---------------- IFU streaming throughput ----------------
        ifu_acc.delete();
        ifu_rsp.delete();
        log_en = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 14'(14'h80 + i), 4'h0, 32'h0, init_word(14'(14'h80 + i)));
        idle(5);
        log_en = 1'b0;
        chk("st_accepts", ifu_acc.size(), 6);
        chk("st_responses", ifu_rsp.size(), 6);
        if (ifu_acc.size() == 6 && ifu_rsp.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("st_accept_cycle", ifu_acc[i] - ifu_acc[0], i);
                chk("st_rsp_cycle", ifu_rsp[i] - ifu_acc[0], i + 2);
            end
        end

        // ---------------- reset with pending responses ----------------
        ifu_rsp_ready = 1'b0;
        send(1'b0, 1'b1, 14'h90, 4'h0, 32'h0, 32'h0);
        send(1'b0, 1'b1, 14'h91, 4'h0, 32'h0, 32'h0);
        idle(3);
        chk("mr_pending_valid", ifu_rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_async_valid", ifu_rsp_valid, 0);
        chk("mr_async_cmd_ready", ifu_cmd_ready, 0);
        exp_q[0].delete();
        @(posedge clk); #3;
        rst = 1'b0;
        ifu_rsp_ready = 1'b1;
        idle(1);
        repeat (4) begin
            @(negedge clk);
            chk("mr_no_stale", ifu_rsp_valid, 0);
        end
        @(posedge clk); #1;
        gord.delete();
        log_en = 1'b1;
        fork
            send(1'b0, 1'b1, 14'h11, 4'h0, 32'h0, init_word(14'h11));
            send(1'b1, 1'b1, 14'h21, 4'h0, 32'h0, init_word(14'h21));
        join
        log_en = 1'b0;
        chk("mr_first_tie_ifu", (gord.size() > 0) ? 32'(gord[0]) : 32'hFFFF, 0);
        idle(5);

        chk("end_ifu_queue_empty", exp_q[0].size(), 0);
        chk("end_lsu_queue_empty", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
